// File: rtl/alu_seq.sv
// alu_seq: registered ALU with single-cycle logic/arithmetic/shift operations
// and an iterative shift-add multiply, using a start/busy/done handshake.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       _function,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             busy,
    output logic             done,
    output logic [3:0]       LED
);

    // Shift-amount field width; derived from WIDTH, never overridden.
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SLL = 3'd5,
        OP_SRL = 3'd6,
        OP_MUL = 3'd7
    } op_e;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               carry_q, carry_d;
    logic               overflow_q, overflow_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [3:0]         led_q, led_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]     cnt_q, cnt_d;

    op_e                op;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_carry;
    logic               alu_ovf;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] acc_step;

    assign op = op_e'(_function);

    // Single-cycle datapath for opcodes 0-6; result and flags of the current inputs.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        sum       = {1'b0, a} + {1'b0, b};
        diff      = {1'b0, a} - {1'b0, b};
        unique case (op)
            OP_ADD: begin
                alu_res   = sum[WIDTH-1:0];
                alu_carry = sum[WIDTH];
                alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res   = diff[WIDTH-1:0];
                alu_carry = diff[WIDTH];  // borrow: set exactly when a < b
                alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_SLL:  alu_res = a << b[SHW-1:0];
            OP_SRL:  alu_res = a >> b[SHW-1:0];
            default: alu_res = '0;  // OP_MUL is handled by the sequencer
        endcase
    end

    // Next-state logic: accept requests in IDLE, iterate the multiply in MUL.
    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        zero_d     = zero_q;
        carry_d    = carry_q;
        overflow_d = overflow_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        led_d      = led_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        acc_step   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    led_d = a[3:0];
                    if (op == OP_MUL) begin
                        mcand_d  = {{WIDTH{1'b0}}, a};
                        mplier_d = b;
                        acc_d    = '0;
                        cnt_d    = '0;
                        busy_d   = 1'b1;
                        state_d  = MUL;
                    end else begin
                        result_d   = alu_res;
                        zero_d     = (alu_res == '0);
                        carry_d    = alu_carry;
                        overflow_d = alu_ovf;
                        done_d     = 1'b1;
                    end
                end
            end
            MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + SHW'(1);
                // Last of WIDTH iterations: publish the low half, flag a non-zero high half.
                if (cnt_q == SHW'(WIDTH - 1)) begin
                    result_d   = acc_step[WIDTH-1:0];
                    zero_d     = (acc_step[WIDTH-1:0] == '0);
                    carry_d    = (acc_step[2*WIDTH-1:WIDTH] != '0);
                    overflow_d = 1'b0;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; async reset aborts any multiply in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the multiply registers are reset too, so an aborted multiply leaves no residue.
            state_q    <= IDLE;
            result_q   <= '0;
            zero_q     <= 1'b0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            led_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            led_q      <= led_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
        end
    end

    assign result   = result_q;
    assign zero     = zero_q;
    assign carry    = carry_q;
    assign overflow = overflow_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign LED      = led_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors with hand-computed expectations for alu_seq (WIDTH=8).
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] _function;
    logic [7:0] result;
    logic       zero;
    logic       carry;
    logic       overflow;
    logic       busy;
    logic       done;
    logic [3:0] LED;

    int n_checks = 0;
    int n_errors = 0;

    alu_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        ._function (_function),
        .result    (result),
        .zero      (zero),
        .carry     (carry),
        .overflow  (overflow),
        .busy      (busy),
        .done      (done),
        .LED       (LED)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one request through one rising edge; returns #1 after that edge.
    task automatic issue(input logic [2:0] fn, input logic [7:0] av, input logic [7:0] bv);
        _function = fn;
        a         = av;
        b         = bv;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Step cycles until done is seen; cyc = cycles stepped, or -1 after the budget.
    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                cyc = i;
                return;
            end
        end
    endtask

    int cyc;
    int pulses;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        _function = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_result", result, 0);
        check("rst_flags", {zero, carry, overflow, busy, done}, 0);
        check("rst_led", LED, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ADD F0+20 = 0x110 -> 0x10 with carry out
        issue(3'd0, 8'hF0, 8'h20);
        check("add_result", result, 8'h10);
        check("add_zco", {zero, carry, overflow}, 3'b010);
        check("add_done", done, 1);
        check("add_led", LED, 4'h0);
        @(posedge clk);
        #1;
        check("add_done_pulse", done, 0);
        check("add_hold", result, 8'h10);

        // SUB 80-01 = 7F, signed overflow; then 01-02 = FF with borrow (back-to-back)
        issue(3'd1, 8'h80, 8'h01);
        check("sub1_result", result, 8'h7F);
        check("sub1_zco", {zero, carry, overflow}, 3'b001);
        issue(3'd1, 8'h01, 8'h02);
        check("sub2_result", result, 8'hFF);
        check("sub2_zco", {zero, carry, overflow}, 3'b010);
        check("sub2_done", done, 1);
        check("sub2_led", LED, 4'h1);

        // Shifts use only b[2:0]; XOR of equal values is zero
        issue(3'd5, 8'h81, 8'h09);
        check("sll_result", result, 8'h02);
        check("sll_zco", {zero, carry, overflow}, 3'b000);
        issue(3'd6, 8'h80, 8'h07);
        check("srl_result", result, 8'h01);
        issue(3'd6, 8'hA5, 8'h08);
        check("srl_by0", result, 8'hA5);
        issue(3'd2, 8'hCC, 8'hAA);
        check("and_result", result, 8'h88);
        issue(3'd3, 8'hC0, 8'h0A);
        check("or_result", result, 8'hCA);
        issue(3'd4, 8'h5A, 8'h5A);
        check("xor_result", result, 8'h00);
        check("xor_zero", zero, 1);

        // MUL 15*17 = 255: busy for 8 cycles, done at edge k+8
        issue(3'd7, 8'd15, 8'd17);
        check("mul1_busy", busy, 1);
        check("mul1_nodone", done, 0);
        check("mul1_result_held", result, 8'h00);
        wait_done(cyc);
        check("mul1_latency", cyc, 8);
        check("mul1_result", result, 8'hFF);
        check("mul1_zcob", {zero, carry, overflow, busy}, 4'b0000);
        check("mul1_led", LED, 4'hF);
        @(posedge clk);
        #1;
        check("mul1_done_pulse", done, 0);

        // MUL 16*16 = 256: low half zero, high half non-zero
        issue(3'd7, 8'd16, 8'd16);
        wait_done(cyc);
        check("mul2_latency", cyc, 8);
        check("mul2_result", result, 8'h00);
        check("mul2_zco", {zero, carry, overflow}, 3'b110);

        // Start with ADD during a MUL is ignored
        issue(3'd7, 8'd3, 8'd5);
        @(posedge clk);
        #1;
        issue(3'd0, 8'h64, 8'h01);
        check("ign_nodone", done, 0);
        check("ign_busy", busy, 1);
        wait_done(cyc);
        check("ign_latency", cyc, 6);
        check("ign_result", result, 8'd15);
        check("ign_led", LED, 4'h3);
        @(posedge clk);
        #1;
        check("ign_no_second_done", done, 0);
        check("ign_hold", result, 8'd15);

        // Async reset during cycle 3 of a MUL aborts it without a done pulse
        issue(3'd7, 8'd15, 8'd17);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_result", result, 0);
        check("abort_flags", {zero, carry, overflow, busy, done}, 0);
        check("abort_led", LED, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("abort_no_done", pulses, 0);
        check("abort_idle", busy, 0);

        issue(3'd0, 8'd1, 8'd1);
        check("post_add_result", result, 8'd2);
        check("post_add_done", done, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the lab's 4-bit combinational ALU.
- WIDTH-bit operands. Supports ADD/SUB/AND/OR/XOR plus logical shifts and an iterative shift-add multiply.
- Uses a start/busy/done handshake and registered status flags.
- Sits between the board switch/operand registers and the LED/seven-segment display logic of the MIPS datapath lab.

Parameters:
- WIDTH, 8, operand/result width in bits (≥4).
- SHW, $clog2(WIDTH), shift-amount field width (derived; not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B (shift amount = b[SHW-1:0]).
- _function  input  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 MUL.
- result  output  WIDTH  registered result; holds until the next completion.
- zero  output  1  result == 0.
- carry  output  1  carry/borrow/overflow-high indicator (see below).
- overflow  output  1  signed overflow (ADD/SUB only).
- busy  output  1  multiply in progress.
- done  output  1  one-cycle completion pulse.
- LED  output  4  a[3:0] latched at accept (debug display).

Behaviour:
- Reset (async, rst_n=0): state=IDLE; result=0, zero=0, carry=0, overflow=0, busy=0, done=0, LED=0; multiply registers cleared. Takes effect immediately, including mid-multiply; the aborted operation produces no done pulse.
- States: IDLE, MUL.
  - IDLE: start=1 at edge k accepts the request and latches LED=a[3:0].
  - IDLE, opcode 0-6: result/flags update at edge k and done=1 for the following cycle. Latency 1; state stays IDLE, so back-to-back starts give one result per cycle.
  - IDLE, opcode 7: load multiplicand={WIDTH'0,a}, multiplier=b, acc=0; busy=1; go to MUL.
  - MUL, each cycle: if multiplier[0], acc+=multiplicand; multiplicand<<=1; multiplier>>=1; step count +1. After WIDTH iterations (edge k+WIDTH), result=acc[WIDTH-1:0], flags update, busy=0, done=1 for one cycle, return to IDLE.
  - MUL: start while busy=1 is ignored (not queued); a, b and _function may change freely.
- done is a single-cycle pulse; done=0 whenever no completion occurs that edge.
- Arithmetic: all unsigned bit-vectors, mod 2^WIDTH.
- Flags for each opcode:
  - ADD: carry=carry-out of a+b; overflow=(a[msb]==b[msb])&&(result[msb]!=a[msb]).
  - SUB: carry=borrow (a<b unsigned); overflow=(a[msb]!=b[msb])&&(result[msb]!=a[msb]).
  - AND/OR/XOR: carry=0, overflow=0.
  - SLL/SRL: zero-fill shift by b[SHW-1:0] only; upper bits of b ignored; carry=0, overflow=0; shift by 0 returns a.
  - MUL: carry=1 iff acc[2*WIDTH-1:WIDTH] != 0; overflow=0.
- zero is computed from the new result value on every completion.
- result and flags change only on a completion edge; between completions they hold.

Test Plan:
- Reset then ADD: a=8'hF0, b=8'h20, start 1 cycle -> next cycle result=8'h10, carry=1, overflow=0, zero=0, done=1 for exactly 1 cycle, LED=4'h0.
- SUB: a=8'h80, b=8'h01 -> result=8'h7F, overflow=1, carry=0. Then a=8'h01, b=8'h02 -> result=8'hFF, carry=1.
- Shifts: SLL a=8'h81, b=8'h09 -> result=8'h02 (amount 1). SRL a=8'h80, b=8'h07 -> 8'h01. XOR a=b=8'h5A -> result=0, zero=1.
- MUL 15×17 -> busy=1 for 8 cycles, then result=8'hFF, carry=0, done pulse at edge k+8. MUL 16×16 -> result=0, zero=1, carry=1.
- Start pulsed with ADD opcode during an active MUL -> ignored; only the MUL done appears and result matches the MUL.
- rst_n pulsed low at cycle 3 of a MUL -> all outputs 0 immediately, busy=0, no done. A following ADD 1+1 -> result=2 after 1 cycle.
